// File: rtl/bus_master_port_if.sv
// Bus master port interface: local command/response handshake plus the
// shared-bus request/grant, address/data and strobe signals.
// The master modport is the bus_master_port view; slave is the environment view.
interface bus_master_port_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) ();

  // Local command channel
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_rw_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_wdata_i;

  // Local response channel
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  // Shared bus / arbiter side
  logic                  barq_o;
  logic                  bagd_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic                  rw_o;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic                  data_strobe_i;
  logic                  error_i;

  modport master (
    input  cmd_valid_i, cmd_rw_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
    input  bagd_i, rdata_i, data_strobe_i, error_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output barq_o, addr_o, wdata_o, rw_o
  );

  modport slave (
    output cmd_valid_i, cmd_rw_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
    output bagd_i, rdata_i, data_strobe_i, error_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  barq_o, addr_o, wdata_o, rw_o
  );

endinterface

// File: rtl/bus_master_port.sv
// Single-master front end for the shared address/data bus.
// Accepts one command at a time, requests the bus, drives it while granted,
// and returns a one-word response. All outputs are registered.
// Optional feature macro: BUS_MASTER_RETRY_EN (retry grant timeout, arbiter
// error and transfer timeout up to twice, with a one-cycle request gap).
module bus_master_port #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned GRANT_TIMEOUT = 32,
  parameter int unsigned XFER_TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  bus_master_port_if.master bus
);

  localparam int unsigned TimerMax =
      (GRANT_TIMEOUT > XFER_TIMEOUT) ? GRANT_TIMEOUT : XFER_TIMEOUT;
  localparam int unsigned TW = $clog2(TimerMax + 1);
  localparam logic [TW-1:0] GrantLast = TW'(GRANT_TIMEOUT - 1);
  localparam logic [TW-1:0] XferLast  = TW'(XFER_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StResp} state_e;

  state_e                state_q;
  logic [TW-1:0]         timer_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  barq_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rw_q;

  // Decoded end-of-attempt conditions
  logic req_active;
  logic grant_to;
  logic xfer_err;
  logic grant_lost;
  logic xfer_to;
  logic xfer_done;
  logic fail_any;
  logic retry_go;

  // In REQ with barq low we are in the retry gap cycle; grant is not sampled.
  assign req_active = (state_q == StReq) && barq_q;
  assign grant_to   = req_active && !bus.bagd_i && (timer_q == GrantLast);
  assign xfer_err   = (state_q == StXfer) && bus.error_i;
  assign grant_lost = (state_q == StXfer) && !bus.error_i && !bus.bagd_i;
  assign xfer_to    = (state_q == StXfer) && !bus.error_i && bus.bagd_i &&
                      !bus.data_strobe_i && (timer_q == XferLast);
  assign xfer_done  = (state_q == StXfer) && !bus.error_i && bus.bagd_i &&
                      bus.data_strobe_i;
  assign fail_any   = grant_to || xfer_err || grant_lost || xfer_to;

`ifdef BUS_MASTER_RETRY_EN
  logic [1:0] retry_q;
  // Loss of grant is not retried; the arbiter has moved on.
  assign retry_go = (grant_to || xfer_err || xfer_to) && (retry_q != 2'd2);
`else
  assign retry_go = 1'b0;
`endif

  // Control FSM with registered outputs; the failure block at the end
  // overrides whatever the state arm scheduled for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      barq_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
`ifdef BUS_MASTER_RETRY_EN
      retry_q     <= 2'd0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid_i && cmd_ready_q) begin
            addr_q      <= bus.cmd_addr_i;
            wdata_q     <= bus.cmd_wdata_i;
            rw_q        <= bus.cmd_rw_i;
            barq_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            timer_q     <= '0;
`ifdef BUS_MASTER_RETRY_EN
            retry_q     <= 2'd0;
`endif
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (!barq_q) begin
            barq_q <= 1'b1;
          end else if (bus.bagd_i) begin
            timer_q <= '0;
            state_q <= StXfer;
          end else if (timer_q != {TW{1'b1}}) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StXfer: begin
          if (xfer_done) begin
            rsp_rdata_q <= rw_q ? '0 : bus.rdata_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            barq_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            state_q     <= StResp;
          end else if (timer_q != {TW{1'b1}}) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StResp: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (fail_any) begin
        if (retry_go) begin
          // Drop the request for one cycle, then re-arbitrate with a fresh timer.
          state_q <= StReq;
          barq_q  <= 1'b0;
          timer_q <= '0;
`ifdef BUS_MASTER_RETRY_EN
          retry_q <= retry_q + 2'd1;
`endif
        end else begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= 1'b1;
          barq_q      <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          rw_q        <= 1'b0;
          state_q     <= StResp;
        end
      end
    end
  end

  assign bus.cmd_ready_o = cmd_ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.barq_o      = barq_q;
  assign bus.addr_o      = addr_q;
  assign bus.wdata_o     = wdata_q;
  assign bus.rw_o        = rw_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed testbench for bus_master_port: write, read with held response,
// grant timeout, arbiter error, reset mid-transfer and back-to-back commands.
module tb_bus_master_port;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

`ifdef BUS_MASTER_RETRY_EN
  localparam int GtoCycles = 98;
  localparam int GtoGaps   = 2;
  localparam int ErrCycles = 8;
`else
  localparam int GtoCycles = 32;
  localparam int GtoGaps   = 0;
  localparam int ErrCycles = 2;
`endif

  bus_master_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bif ();

  bus_master_port #(
    .ADDR_WIDTH   (16),
    .DATA_WIDTH   (16),
    .GRANT_TIMEOUT(32),
    .XFER_TIMEOUT (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.cmd_valid_i   = 1'b0;
    bif.cmd_rw_i      = 1'b0;
    bif.cmd_addr_i    = '0;
    bif.cmd_wdata_i   = '0;
    bif.rsp_ready_i   = 1'b0;
    bif.bagd_i        = 1'b0;
    bif.rdata_i       = '0;
    bif.data_strobe_i = 1'b0;
    bif.error_i       = 1'b0;
  endtask

  // Handshake in the current cycle; returns in the first REQ cycle.
  task automatic send_cmd(input logic rw, input logic [15:0] addr, input logic [15:0] wdata);
    check_eq("cmd_ready_before_cmd", 32'(bif.cmd_ready_o), 32'd1);
    bif.cmd_valid_i = 1'b1;
    bif.cmd_rw_i    = rw;
    bif.cmd_addr_i  = addr;
    bif.cmd_wdata_i = wdata;
    tick();
    bif.cmd_valid_i = 1'b0;
  endtask

  task automatic consume_rsp();
    bif.rsp_ready_i = 1'b1;
    tick();
    bif.rsp_ready_i = 1'b0;
    check_eq("idle_after_rsp", {31'd0, bif.cmd_ready_o}, 32'd1);
  endtask

  initial begin
    int c;
    int gaps;
    int hs1;
    int hs2;
    int nhs;
    logic saw_valid;
    logic saw_err;

    clear_inputs();
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    check_eq("rst_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);
    check_eq("rst_ctrl", {27'd0, bif.rsp_valid_o, bif.rsp_err_o, bif.barq_o, bif.rw_o, 1'b0}, 32'd0);
    check_eq("rst_addr", 32'(bif.addr_o), 32'd0);
    check_eq("rst_data", {bif.wdata_o, bif.rsp_rdata_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Write: grant at N+1, strobe at N+3, response at N+4
    send_cmd(1'b1, 16'h101E, 16'd99);
    check_eq("wr_req_barq", 32'(bif.barq_o), 32'd1);
    check_eq("wr_req_addr", 32'(bif.addr_o), 32'h101E);
    check_eq("wr_req_cmd_ready", 32'(bif.cmd_ready_o), 32'd0);
    bif.bagd_i = 1'b1;
    tick();
    check_eq("wr_xfer_bus", {bif.addr_o, bif.wdata_o}, {16'h101E, 16'd99});
    check_eq("wr_xfer_rw_barq", {30'd0, bif.rw_o, bif.barq_o}, 32'd3);
    tick();
    check_eq("wr_xfer_no_rsp", 32'(bif.rsp_valid_o), 32'd0);
    bif.data_strobe_i = 1'b1;
    bif.rdata_i       = 16'h1234;
    tick();
    bif.data_strobe_i = 1'b0;
    bif.bagd_i        = 1'b0;
    bif.rdata_i       = '0;
    check_eq("wr_rsp_valid", 32'(bif.rsp_valid_o), 32'd1);
    check_eq("wr_rsp_err", 32'(bif.rsp_err_o), 32'd0);
    check_eq("wr_rsp_rdata", 32'(bif.rsp_rdata_o), 32'd0);
    check_eq("wr_rsp_bus_idle", {bif.addr_o, bif.wdata_o}, 32'd0);
    check_eq("wr_rsp_barq", {30'd0, bif.barq_o, bif.rw_o}, 32'd0);
    consume_rsp();

    // Read with response held for 5 cycles
    send_cmd(1'b0, 16'h1005, 16'd0);
    check_eq("rd_req_rw", 32'(bif.rw_o), 32'd0);
    bif.bagd_i = 1'b1;
    tick();
    bif.data_strobe_i = 1'b1;
    bif.rdata_i       = 16'hBEEF;
    tick();
    bif.data_strobe_i = 1'b0;
    bif.bagd_i        = 1'b0;
    bif.rdata_i       = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rd_hold_valid_%0d", i), 32'(bif.rsp_valid_o), 32'd1);
      check_eq($sformatf("rd_hold_data_%0d", i), {15'd0, bif.rsp_err_o, bif.rsp_rdata_o},
               32'h0000BEEF);
      tick();
    end
    check_eq("rd_no_cmd_ready_pending", 32'(bif.cmd_ready_o), 32'd0);
    consume_rsp();
    bif.rdata_i = '0;

    // Grant timeout: grant never given
    send_cmd(1'b1, 16'h0042, 16'h0007);
    c    = 0;
    gaps = 0;
    while (!bif.rsp_valid_o && c < 300) begin
      if (!bif.barq_o) gaps++;
      tick();
      c++;
    end
    check_eq("gto_cycles", 32'(c), 32'(GtoCycles));
    check_eq("gto_barq_gaps", 32'(gaps), 32'(GtoGaps));
    check_eq("gto_err", {30'd0, bif.rsp_valid_o, bif.rsp_err_o}, 32'd3);
    consume_rsp();

    // Arbiter error together with strobe: error wins, rdata forced to 0
    send_cmd(1'b0, 16'h1005, 16'd0);
    bif.bagd_i        = 1'b1;
    bif.error_i       = 1'b1;
    bif.data_strobe_i = 1'b1;
    bif.rdata_i       = 16'h5555;
    c = 0;
    while (!bif.rsp_valid_o && c < 50) begin
      tick();
      c++;
    end
    check_eq("aerr_cycles", 32'(c), 32'(ErrCycles));
    check_eq("aerr_err", {30'd0, bif.rsp_valid_o, bif.rsp_err_o}, 32'd3);
    check_eq("aerr_rdata", 32'(bif.rsp_rdata_o), 32'd0);
    clear_inputs();
    consume_rsp();

    // Reset during XFER aborts with no response
    send_cmd(1'b1, 16'h2000, 16'h0077);
    bif.bagd_i = 1'b1;
    tick();
    check_eq("mid_xfer_addr", 32'(bif.addr_o), 32'h2000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bif.bagd_i = 1'b0;
    check_eq("mid_rst_ctrl", {27'd0, bif.cmd_ready_o, bif.rsp_valid_o, bif.rsp_err_o,
             bif.barq_o, bif.rw_o}, 32'h10);
    check_eq("mid_rst_bus", {bif.addr_o, bif.wdata_o}, 32'd0);
    check_eq("mid_rst_rdata", 32'(bif.rsp_rdata_o), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bif.rsp_valid_o) saw_valid = 1'b1;
      tick();
    end
    check_eq("mid_rst_no_rsp", 32'(saw_valid), 32'd0);
    send_cmd(1'b1, 16'h2002, 16'h00AA);
    check_eq("post_rst_bus", {bif.addr_o, bif.wdata_o}, {16'h2002, 16'h00AA});
    bif.bagd_i = 1'b1;
    tick();
    bif.data_strobe_i = 1'b1;
    tick();
    clear_inputs();
    check_eq("post_rst_rsp", {30'd0, bif.rsp_valid_o, bif.rsp_err_o}, 32'd2);
    consume_rsp();

    // Back-to-back writes at the fastest grant/strobe
    bif.bagd_i        = 1'b1;
    bif.data_strobe_i = 1'b1;
    bif.rsp_ready_i   = 1'b1;
    bif.cmd_valid_i   = 1'b1;
    bif.cmd_rw_i      = 1'b1;
    bif.cmd_addr_i    = 16'h3000;
    bif.cmd_wdata_i   = 16'h0001;
    hs1     = -1;
    hs2     = -1;
    nhs     = 0;
    saw_err = 1'b0;
    c       = 0;
    while (nhs < 2 && c < 20) begin
      if (bif.rsp_err_o) saw_err = 1'b1;
      if (bif.cmd_valid_i && bif.cmd_ready_o) begin
        if (nhs == 0) hs1 = c;
        else hs2 = c;
        nhs++;
      end
      tick();
      c++;
      bif.cmd_wdata_i = 16'h0002;
    end
    bif.cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bif.rsp_err_o) saw_err = 1'b1;
      tick();
    end
    check_eq("b2b_handshakes", 32'(nhs), 32'd2);
    check_eq("b2b_spacing", 32'(hs2 - hs1), 32'd4);
    check_eq("b2b_no_err", 32'(saw_err), 32'd0);
    clear_inputs();
    tick();
    check_eq("b2b_idle", {30'd0, bif.cmd_ready_o, bif.barq_o}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
